// File: rtl/mem_access_unit.sv
// Memory-stage load/store sequencer: alignment check, split addr_ok/data_ok bus
// transaction, byte-strobe generation and load-data extraction/extension.
module mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_wr,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [1:0]          in_size,
  input  logic                in_sign,
  input  logic [DATA_W-1:0]   in_wdata,
  input  logic                flush,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_error,
  output logic [ADDR_W-1:0]   resp_badvaddr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RESP,
    S_DRAIN
  } state_t;

  state_t              r_state;
  logic                r_wr;
  logic [ADDR_W-1:0]   r_addr;
  logic [1:0]          r_size;
  logic                r_sign;
  logic [DATA_W/8-1:0] r_wstrb;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_mem_req;
  logic                r_resp_valid;
  logic                r_resp_error;
  logic [DATA_W-1:0]   r_resp_rdata;
  logic [ADDR_W-1:0]   r_badvaddr;

  logic                w_accept;
  logic                w_misalign;
  logic [DATA_W/8-1:0] w_wstrb;
  logic [DATA_W-1:0]   w_wdata;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [DATA_W-1:0]   w_fmt;
  logic [DATA_W-1:0]   w_load_data;

  assign w_accept   = in_valid && (r_state == S_IDLE) && !flush;
  assign w_misalign = ((in_size == 2'b11) && (in_addr[1:0] != 2'b00)) ||
                      ((in_size == 2'b01) && in_addr[0]);

  always_comb begin
    w_wstrb = '1;
    w_wdata = in_wdata;
    case (in_size)
      2'b00: begin
        w_wstrb = 4'b0001 << in_addr[1:0];
        w_wdata = {4{in_wdata[7:0]}};
      end
      2'b01: begin
        w_wstrb = in_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{in_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Formatting uses the captured request, so it is valid in both ADDR and DATA.
  always_comb begin
    w_byte = mem_rdata[8*r_addr[1:0] +: 8];
    w_half = mem_rdata[16*r_addr[1] +: 16];
    w_fmt  = mem_rdata;
    case (r_size)
      2'b00:   w_fmt = {{24{r_sign & w_byte[7]}}, w_byte};
      2'b01:   w_fmt = {{16{r_sign & w_half[15]}}, w_half};
      default: ;
    endcase
    w_load_data = r_wr ? '0 : w_fmt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_wr         <= 1'b0;
      r_addr       <= '0;
      r_size       <= '0;
      r_sign       <= 1'b0;
      r_wstrb      <= '0;
      r_wdata      <= '0;
      r_mem_req    <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_error <= 1'b0;
      r_resp_rdata <= '0;
      r_badvaddr   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_wr         <= in_wr;
            r_addr       <= in_addr;
            r_size       <= in_size;
            r_sign       <= in_sign;
            r_resp_rdata <= '0;
            if (w_misalign) begin
              r_wstrb      <= '0;
              r_wdata      <= '0;
              r_resp_valid <= 1'b1;
              r_resp_error <= 1'b1;
              r_badvaddr   <= in_addr;
              r_state      <= S_RESP;
            end else begin
              r_wstrb      <= in_wr ? w_wstrb : '0;
              r_wdata      <= in_wr ? w_wdata : '0;
              r_mem_req    <= 1'b1;
              r_resp_error <= 1'b0;
              r_badvaddr   <= '0;
              r_state      <= S_ADDR;
            end
          end
        end
        S_ADDR: begin
          if (mem_addr_ok) begin
            r_mem_req <= 1'b0;
            if (mem_data_ok) begin
              // Transaction already complete on the bus; a flush only drops the response.
              if (flush) begin
                r_state <= S_IDLE;
              end else begin
                r_resp_rdata <= w_load_data;
                r_resp_valid <= 1'b1;
                r_state      <= S_RESP;
              end
            end else begin
              r_state <= flush ? S_DRAIN : S_DATA;
            end
          end else if (flush) begin
            r_mem_req <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        S_DATA: begin
          if (mem_data_ok) begin
            if (flush) begin
              r_state <= S_IDLE;
            end else begin
              r_resp_rdata <= w_load_data;
              r_resp_valid <= 1'b1;
              r_state      <= S_RESP;
            end
          end else if (flush) begin
            r_state <= S_DRAIN;
          end
        end
        S_RESP: begin
          if (resp_ready || flush) begin
            r_resp_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (mem_data_ok) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready      = (r_state == S_IDLE);
  assign mem_req       = r_mem_req;
  assign mem_wr        = r_wr;
  assign mem_addr      = {r_addr[ADDR_W-1:2], 2'b00};
  assign mem_wstrb     = r_wstrb;
  assign mem_wdata     = r_wdata;
  assign resp_valid    = r_resp_valid;
  assign resp_rdata    = r_resp_rdata;
  assign resp_error    = r_resp_error;
  assign resp_badvaddr = r_badvaddr;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plus randomized checks of mem_access_unit against an arithmetic
// reference of strobes, lane replication and load extraction.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_wr, in_sign, flush;
  logic [31:0] in_addr, in_wdata;
  logic [1:0]  in_size;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        resp_valid, resp_ready, resp_error;
  logic [31:0] resp_rdata, resp_badvaddr;

  int errors = 0;
  int checks = 0;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_wr(in_wr), .in_addr(in_addr),
    .in_size(in_size), .in_sign(in_sign), .in_wdata(in_wdata), .flush(flush),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error), .resp_badvaddr(resp_badvaddr)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_load(input logic [1:0] size, input logic sign,
                                           input logic [31:0] addr, input logic [31:0] rd);
    logic [31:0] v;
    int unsigned off;
    off = addr % 4;
    case (size)
      2'd0: begin
        v = (rd >> (8 * off)) & 32'hFF;
        if (sign && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end
      2'd1: begin
        v = (rd >> (16 * (off / 2))) & 32'hFFFF;
        if (sign && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  task automatic access(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                        input logic sign, input logic [31:0] wdata, input int alat,
                        input int dlat, input logic [31:0] rdata, input int rlat);
    logic        mis;
    logic [3:0]  es;
    logic [31:0] ew, er, held;
    int unsigned off;
    off = addr % 4;
    mis = (size == 2'd3 && off != 0) || (size == 2'd1 && off % 2 != 0);
    if (!wr) es = 4'h0;
    else if (size == 2'd0) es = 4'(1 << off);
    else if (size == 2'd1) es = (off >= 2) ? 4'hC : 4'h3;
    else es = 4'hF;
    if (size == 2'd0) ew = (wdata & 32'hFF) * 32'h0101_0101;
    else if (size == 2'd1) ew = (wdata & 32'hFFFF) * 32'h0001_0001;
    else ew = wdata;
    er = wr ? 32'h0 : exp_load(size, sign, addr, rdata);

    chk("idle_in_ready", in_ready, 1);
    in_valid = 1'b1; in_wr = wr; in_addr = addr; in_size = size;
    in_sign = sign; in_wdata = wdata;
    step();
    in_valid = 1'b0; in_wdata = $urandom;
    if (mis) begin
      chk("err_resp_valid", resp_valid, 1);
      chk("err_resp_error", resp_error, 1);
      chk("err_badvaddr", resp_badvaddr, addr);
      chk("err_no_mem_req", mem_req, 0);
      chk("err_rdata_zero", resp_rdata, 0);
    end else begin
      chk("addr_mem_req", mem_req, 1);
      chk("addr_mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
      chk("addr_mem_wr", mem_wr, wr);
      chk("addr_mem_wstrb", mem_wstrb, es);
      if (wr) chk("addr_mem_wdata", mem_wdata, ew);
      for (int i = 0; i < alat; i++) begin
        step();
        chk("addr_hold_req", mem_req, 1);
        chk("addr_hold_addr", mem_addr, addr & 32'hFFFF_FFFC);
        chk("addr_hold_strb", mem_wstrb, es);
      end
      mem_addr_ok = 1'b1;
      if (dlat == 0) begin mem_data_ok = 1'b1; mem_rdata = rdata; end
      step();
      mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = $urandom;
      if (dlat > 0) begin
        chk("data_req_low", mem_req, 0);
        chk("data_no_resp", resp_valid, 0);
        for (int i = 1; i < dlat; i++) step();
        mem_data_ok = 1'b1; mem_rdata = rdata;
        step();
        mem_data_ok = 1'b0; mem_rdata = $urandom;
      end
      chk("resp_valid", resp_valid, 1);
      chk("resp_error", resp_error, 0);
      chk("resp_rdata", resp_rdata, er);
    end
    held = resp_rdata;
    for (int i = 0; i < rlat; i++) begin
      step();
      chk("resp_hold_valid", resp_valid, 1);
      chk("resp_hold_rdata", resp_rdata, held);
      chk("resp_hold_ready", in_ready, 0);
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("resp_done_valid", resp_valid, 0);
    chk("resp_done_ready", in_ready, 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; in_wr = 0; in_addr = 0; in_size = 0; in_sign = 0;
    in_wdata = 0; flush = 0; mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    resp_ready = 0;
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_error", resp_error, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wstrb", mem_wstrb, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_badvaddr", resp_badvaddr, 0);
    step(); step();
    rst = 1'b0;
    step();

    access(0, 32'h1000, 2'd3, 0, 0, 2, 1, 32'hDEAD_BEEF, 0);
    access(0, 32'h1002, 2'd1, 1, 0, 0, 1, 32'h8001_1234, 0);
    chk("half_sext_direct", resp_rdata, 32'hFFFF_8001);
    access(0, 32'h1002, 2'd1, 0, 0, 0, 1, 32'h8001_1234, 0);
    chk("half_zext_direct", resp_rdata, 32'h0000_8001);
    access(1, 32'h1003, 2'd0, 0, 32'h0000_00AB, 1, 2, 32'h1111_1111, 0);
    access(0, 32'h1006, 2'd3, 0, 0, 0, 0, 0, 0);
    access(0, 32'h1003, 2'd1, 1, 0, 0, 0, 0, 1);
    access(0, 32'h1003, 2'd2, 0, 0, 0, 1, 32'hCAFE_F00D, 0);
    access(1, 32'h1003, 2'd2, 0, 32'h1234_5678, 0, 1, 0, 0);
    access(0, 32'h1001, 2'd0, 1, 0, 0, 0, 32'h0000_8000, 3);

    // Flush in IDLE blocks acceptance
    in_valid = 1; in_wr = 0; in_addr = 32'h2000; in_size = 2'd3; flush = 1;
    step();
    in_valid = 0; flush = 0;
    chk("idle_flush_noreq", mem_req, 0);
    chk("idle_flush_ready", in_ready, 1);

    // Flush in ADDR without addr_ok
    in_valid = 1; in_addr = 32'h2004;
    step();
    in_valid = 0;
    chk("aflush_req_up", mem_req, 1);
    flush = 1;
    step();
    flush = 0;
    chk("aflush_req_down", mem_req, 0);
    chk("aflush_idle", in_ready, 1);
    chk("aflush_noresp", resp_valid, 0);

    // Flush in DATA before data_ok -> drain
    in_valid = 1; in_addr = 32'h2008;
    step();
    in_valid = 0; mem_addr_ok = 1;
    step();
    mem_addr_ok = 0; flush = 1;
    step();
    flush = 0;
    for (int i = 0; i < 3; i++) begin
      chk("drain_ready_low", in_ready, 0);
      chk("drain_req_low", mem_req, 0);
      chk("drain_noresp", resp_valid, 0);
      step();
    end
    mem_data_ok = 1; mem_rdata = 32'h5555_AAAA;
    step();
    mem_data_ok = 0;
    chk("drain_done_ready", in_ready, 1);
    chk("drain_done_noresp", resp_valid, 0);

    // Flush in RESP
    in_valid = 1; in_addr = 32'h200C;
    step();
    in_valid = 0; mem_addr_ok = 1; mem_data_ok = 1;
    step();
    mem_addr_ok = 0; mem_data_ok = 0;
    chk("rflush_valid", resp_valid, 1);
    flush = 1;
    step();
    flush = 0;
    chk("rflush_drop", resp_valid, 0);
    chk("rflush_ready", in_ready, 1);

    for (int n = 0; n < 40; n++) begin
      access(1'($urandom_range(0, 1)), 32'h4000 + ($urandom_range(0, 255) & 32'hFF),
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom,
             $urandom_range(0, 3), $urandom_range(0, 2), $urandom, $urandom_range(0, 2));
    end

    // Async reset mid-DATA on a store
    in_valid = 1; in_wr = 1; in_addr = 32'h3001; in_size = 2'd0; in_wdata = 32'h5A;
    step();
    in_valid = 0; mem_addr_ok = 1;
    step();
    mem_addr_ok = 0;
    chk("pre_rst_strb", mem_wstrb, 4'b0010);
    #2 rst = 1;
    #1;
    chk("arst_mem_req", mem_req, 0);
    chk("arst_mem_wr", mem_wr, 0);
    chk("arst_mem_wstrb", mem_wstrb, 0);
    chk("arst_mem_addr", mem_addr, 0);
    chk("arst_resp_valid", resp_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    #1 rst = 0;
    step();
    chk("post_rst_idle", in_ready, 1);
    access(0, 32'h3002, 2'd0, 1, 0, 1, 1, 32'h00F0_0000, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Memory-stage load/store sequencer placed directly after the access-size alignment check in the MIPS pipeline.
- Accepts one access per handshake from EX/MEM and flags misaligned accesses as address-error exceptions without touching the bus.
- Drives aligned accesses onto the split addr_ok/data_ok data-memory interface, generating byte strobes and lane-replicated store data.
- Returns byte/half/word-extracted, sign- or zero-extended load data to writeback.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; fixed at 32, and strobe width is DATA_W/8.

Ports:
- clk  in  1  clock; rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  access request from pipeline.
- in_ready  out  1  unit can accept an access.
- in_wr  in  1  1=store, 0=load.
- in_addr  in  32  byte address.
- in_size  in  2  00 byte, 01 half, 10 unaligned-word (LWL/LWR/SWL/SWR class), 11 word.
- in_sign  in  1  loads: 1=sign-extend, 0=zero-extend.
- in_wdata  in  32  store data, right-justified.
- flush  in  1  pipeline flush; kill the in-flight access.
- mem_req  out  1  bus address-phase request.
- mem_wr  out  1  bus write.
- mem_addr  out  32  word-aligned bus address {addr[31:2],2'b00}.
- mem_wstrb  out  4  byte strobes; 0000 on loads.
- mem_wdata  out  32  lane-replicated store data.
- mem_addr_ok  in  1  address phase accepted.
- mem_data_ok  in  1  data phase complete.
- mem_rdata  in  32  read data, valid with mem_data_ok.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes result.
- resp_rdata  out  32  formatted load data; 0 on stores and errors.
- resp_error  out  1  address error.
- resp_badvaddr  out  32  faulting address; valid when resp_error=1.

Behaviour:
- States: IDLE, ADDR, DATA, RESP, DRAIN.
- Reset: state IDLE; mem_req, resp_valid, resp_error = 0; all data/address registers = 0.
- in_ready = (state==IDLE). Accept on in_valid&&in_ready; capture wr, addr, size, sign, wdata.
- Misaligned when size==11 && addr[1:0]!=0, or size==01 && addr[0]!=0. Sizes 00 and 10 are never misaligned.
- Misaligned accept: go directly to RESP with resp_error=1 and resp_badvaddr=addr. mem_req never asserts.
- Aligned accept: go to ADDR.
- ADDR: mem_req=1. mem_addr, mem_wr, mem_wstrb and mem_wdata are held stable until mem_addr_ok.
  - mem_addr_ok && mem_data_ok in the same cycle: go to RESP.
  - mem_addr_ok alone: go to DATA.
- DATA: mem_req=0. On mem_data_ok, latch formatted data and go to RESP.
- RESP: resp_valid=1; outputs held until resp_ready, then go to IDLE.
  - A new access is not accepted in the same cycle; minimum issue interval is 3 cycles for zero-wait bus.
- Store strobes:
  - byte: 0001<<addr[1:0], data {4{b}}.
  - half: addr[1]?1100:0011, data {2{h}}.
  - word and size 10: 1111, data as given.
- Load formatting:
  - byte: rdata[8*addr[1:0]+:8].
  - half: rdata[16*addr[1]+:16].
  - Extend to 32 per sign.
  - word and size 10: rdata unmodified; merging for the 10 class is done downstream.
- flush:
  - In ADDR before/without mem_addr_ok: go to IDLE, drop mem_req the next cycle, no response.
  - In ADDR with mem_addr_ok same cycle and no data_ok: go to DRAIN.
  - In DATA without data_ok: go to DRAIN.
  - In DATA with data_ok same cycle: go to IDLE, response suppressed.
  - In RESP: go to IDLE, resp_valid drops the next cycle.
  - In IDLE: blocks acceptance that cycle.
- DRAIN: in_ready=0, mem_req=0; wait for mem_data_ok, discard the data, then go to IDLE.
  - An outstanding transaction is never abandoned on the bus.
- rst asserted mid-transaction: immediate return to IDLE with all outputs cleared.
  - The bus side must be reset with the same rst.

Test Plan:
- Load word 0x1000, size 11, addr_ok after 2 cycles, data_ok +1 with rdata 0xDEADBEEF -> mem_wstrb=0000, resp_rdata=0xDEADBEEF, resp_error=0.
- Load half 0x1002 sign=1, rdata 0x8001_1234 -> mem_addr=0x1000, resp_rdata=0xFFFF8001; same access with sign=0 -> 0x00008001.
- Store byte 0x1003, wdata 0x000000AB -> mem_wstrb=1000, mem_wdata=0xABABABAB, mem_wr=1, resp_rdata=0.
- Load word 0x1006 -> no mem_req ever, RESP next cycle with resp_error=1, resp_badvaddr=0x1006; half at 0x1003 -> error. Size 10 at 0x1003 -> bus access with mem_addr=0x1000, wstrb 0000.
- Flush in DATA before data_ok -> enters DRAIN, in_ready=0 until the late data_ok, no resp_valid. Flush in ADDR with no addr_ok -> mem_req drops next cycle, IDLE.
- Zero-wait bus (addr_ok & data_ok same cycle) with resp_ready held low 3 cycles -> resp outputs stable, in_ready=0 throughout. Async rst pulse mid-DATA -> outputs clear without a clock edge.
